// File: rtl/adc_window_stats.sv
// Windowed statistics (max/min/mean/peak-to-peak/over-range) over 2**WIN_LOG2 valid ADC samples.
// Optional over-range counting is compiled in with `define ADC_STATS_OVR_EN.
module adc_window_stats #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned WIN_LOG2 = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   sample_in,
   input  logic                sample_valid,
   input  logic                ovr_in,
   input  logic                enable,
   input  logic [1:0]          disp_sel,
   output logic                busy,
   output logic                stat_valid,
   output logic [DATA_W-1:0]   max_out,
   output logic [DATA_W-1:0]   min_out,
   output logic [DATA_W-1:0]   mean_out,
   output logic [DATA_W-1:0]   pp_out,
   output logic [WIN_LOG2:0]   ovr_count,
   output logic [DATA_W-1:0]   display
);

   localparam int unsigned SUM_W = DATA_W + WIN_LOG2;
   localparam int unsigned CNT_W = WIN_LOG2;
   localparam int unsigned OVR_W = WIN_LOG2 + 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   state_t                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic signed [DATA_W-1:0]  run_max_q;
   logic signed [DATA_W-1:0]  run_min_q;
   logic signed [SUM_W-1:0]   sum_q;

   logic signed [DATA_W-1:0]  smp;
   logic signed [DATA_W-1:0]  max_d;
   logic signed [DATA_W-1:0]  min_d;
   logic signed [SUM_W-1:0]   sum_d;
   logic [DATA_W-1:0]         mean_d;
   logic [DATA_W-1:0]         pp_d;
   logic                      accept;
   logic                      abort;
   logic                      first;
   logic                      last;

   assign smp    = $signed(sample_in);
   assign accept = (state_q == ST_ACCUM) && enable && sample_valid;
   assign abort  = (state_q == ST_ACCUM) && !enable;
   assign first  = (cnt_q == '0);
   assign last   = (cnt_q == {CNT_W{1'b1}});

   // Running statistics including the sample presented this cycle
   always_comb begin
      max_d = run_max_q;
      min_d = run_min_q;
      if (first || (smp > run_max_q)) max_d = smp;
      if (first || (smp < run_min_q)) min_d = smp;
      sum_d  = sum_q + $signed({{WIN_LOG2{smp[DATA_W-1]}}, smp});
      mean_d = DATA_W'(sum_d >>> WIN_LOG2);
      // One extra bit so the signed difference cannot wrap; the result always fits DATA_W unsigned
      pp_d   = DATA_W'({max_d[DATA_W-1], max_d} - {min_d[DATA_W-1], min_d});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         busy       <= 1'b0;
         stat_valid <= 1'b0;
         cnt_q      <= '0;
         run_max_q  <= '0;
         run_min_q  <= '0;
         sum_q      <= '0;
         max_out    <= '0;
         min_out    <= '0;
         mean_out   <= '0;
         pp_out     <= '0;
      end else begin
         stat_valid <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  state_q <= ST_ACCUM;
                  busy    <= 1'b1;
               end
            end
            ST_ACCUM: begin
               if (!enable) begin
                  // Drop the partial window; results keep their last published values
                  state_q   <= ST_IDLE;
                  busy      <= 1'b0;
                  cnt_q     <= '0;
                  run_max_q <= '0;
                  run_min_q <= '0;
                  sum_q     <= '0;
               end else if (sample_valid) begin
                  if (last) begin
                     max_out    <= max_d;
                     min_out    <= min_d;
                     mean_out   <= mean_d;
                     pp_out     <= pp_d;
                     stat_valid <= 1'b1;
                     cnt_q      <= '0;
                     run_max_q  <= '0;
                     run_min_q  <= '0;
                     sum_q      <= '0;
                  end else begin
                     cnt_q     <= cnt_q + CNT_W'(1);
                     run_max_q <= max_d;
                     run_min_q <= min_d;
                     sum_q     <= sum_d;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef ADC_STATS_OVR_EN
   logic [OVR_W-1:0] ovr_cnt_q;
   logic [OVR_W-1:0] ovr_cnt_d;

   assign ovr_cnt_d = ovr_cnt_q + OVR_W'(ovr_in);

   // Over-range tally follows the same accept/clear rules as the other accumulators
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovr_cnt_q <= '0;
         ovr_count <= '0;
      end else if (accept) begin
         if (last) begin
            ovr_count <= ovr_cnt_d;
            ovr_cnt_q <= '0;
         end else begin
            ovr_cnt_q <= ovr_cnt_d;
         end
      end else if (abort) begin
         ovr_cnt_q <= '0;
      end
   end
`else
   logic unused_ovr;
   logic unused_ctl;
   assign unused_ovr = ovr_in;
   assign unused_ctl = accept ^ abort;
   assign ovr_count  = '0;
`endif

   // Display mux over the registered results
   always_comb begin
      display = max_out;
      case (disp_sel)
         2'd0:    display = max_out;
         2'd1:    display = min_out;
         2'd2:    display = mean_out;
         2'd3:    display = pp_out;
         default: display = max_out;
      endcase
   end

endmodule

// File: doc/adc_window_stats.md
Name: adc_window_stats

Overview:
- Downstream consumer of the 16-bit ADC sample word produced by the DDR capture stage (ddr_generic q), clocked on the same ddr_sclk domain.
- Accumulates fixed-length windows of valid samples and publishes per-window max, min, mean, peak-to-peak and over-range count.
- Drives a selectable 16-bit display word that replaces the raw sample currently wired to the seg_1..seg_16 LEDs.

Parameters:
- DATA_W, 16, sample width; samples are two's complement.
- WIN_LOG2, 10, window length = 2**WIN_LOG2 valid samples.

Ports:
- clk  in  1  sample clock (ddr_sclk domain).
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- sample_in  in  DATA_W  signed ADC sample.
- sample_valid  in  1  sample_in qualifier; one sample per cycle maximum.
- ovr_in  in  1  ADC over-range flag, aligned with sample_in.
- enable  in  1  level; 1 = run windows, 0 = idle.
- disp_sel  in  2  display select: 0 max, 1 min, 2 mean, 3 peak-to-peak.
- busy  out  1  high while a window is in progress.
- stat_valid  out  1  one-cycle pulse when new results are loaded.
- max_out  out  DATA_W  signed window maximum.
- min_out  out  DATA_W  signed window minimum.
- mean_out  out  DATA_W  signed window mean.
- pp_out  out  DATA_W  unsigned max minus min.
- ovr_count  out  WIN_LOG2+1  count of valid samples with ovr_in=1.
- display  out  DATA_W  result selected by disp_sel.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs, accumulators, window counter and state go to 0.
  - State = IDLE.
- States:
  - IDLE: busy=0; sample_valid ignored; goes to ACCUM the cycle after enable=1 is sampled.
  - ACCUM: busy=1; each valid sample is accepted.
- Accumulation, per accepted sample:
  - First sample of a window initialises running max and min.
  - Later samples update max and min with signed compare.
  - Sum accumulator: signed, DATA_W+WIN_LOG2 bits, cannot overflow.
  - Window counter increments.
- Window end (accepted sample with count = 2**WIN_LOG2-1):
  - Final values include that sample.
  - Registered outputs load on that clock edge.
  - mean_out = sum arithmetic-shifted right by WIN_LOG2 (floor, rounds toward -inf).
  - pp_out = max-min, computed DATA_W+1 bits wide; the result always fits in DATA_W unsigned.
  - stat_valid = 1 for exactly the following cycle.
  - Accumulators and counter clear on the same edge, so the next window accepts a sample on the very next cycle with no gap and no dropped sample.
- sample_valid=0 cycles do not advance the window; gaps are allowed.
- enable=0 during ACCUM:
  - Partial window is discarded; state returns to IDLE next cycle.
  - No stat_valid pulse; result outputs hold their last values.
  - A sample valid on that same cycle is discarded.
- Re-entry to ACCUM always starts a fresh window.
- Result outputs change only at window end or reset.
- display is a combinational mux of the registered results. For disp_sel=3 it shows pp_out.
- Latency: last sample edge to stat_valid high = 1 cycle; results are valid on the same cycle stat_valid is high.

Optional Feature:
- Macro: ADC_STATS_OVR_EN.
- Defined: ovr_count counts accepted samples with ovr_in=1, range 0..2**WIN_LOG2. It is loaded at window end and the internal count clears with the other accumulators.
- Undefined: ovr_in is ignored, counter logic is removed, and ovr_count is tied to 0.
- Ports are identical in both builds.

Test Plan:
(All scenarios WIN_LOG2=2, DATA_W=16.)
1. Reset: hold reset=0 with random inputs -> all outputs 0, busy=0, stat_valid=0. Release with enable=0 -> still 0.
2. Basic window: enable=1, then valid samples 100, -50, 300, 2 on consecutive cycles -> stat_valid pulses once, one cycle after the 4th sample, with:
   - max_out=0x012C, min_out=0xFFCE
   - mean_out=0x0058 (88), pp_out=0x015E (350)
   - display follows disp_sel 0..3.
3. Gaps and back-to-back windows:
   - Same 4 samples with 2 idle cycles between each -> identical results.
   - Then 0x7FFF x4 immediately followed by 0x8000 x4, all consecutive -> two pulses 4 cycles apart:
     - first window: max=min=mean=0x7FFF, pp=0
     - second window: max=min=mean=0x8000, pp=0.
4. Abort: after scenario 2, 2 samples then enable=0 -> no pulse, outputs still hold scenario 2 values. Re-enable, then 7, 7, 7, 11 -> mean=8, pp=4, max=11, min=7.
5. Over-range (macro defined): ovr_in=1 on 3 of the 4 valid samples plus 2 invalid cycles -> ovr_count=3. Macro undefined -> ovr_count=0.
6. Reset mid-window: reset=0 after 3 samples -> outputs 0 immediately, before the next edge. After release and enable, a full 4-sample window is required before stat_valid.
